layer_seq_ctrl: RTL and testbench

Sequencing controller for one matrix-vector layer of the MVM pipeline. Accepts an N-element input vector over a valid/ready stream and drives the write port of the layer's x-memory. It then walks the x-memory and weight ROM row by row, controlling the MAC accumulator. After each row it presents the accumulated result downstream with valid/ready backpressure. Layers are chained stream-to-stream, so this block's handshakes face the previous and next layer directly.

---
 rtl/layer_seq_ctrl.sv | 108 ++++++++++
 tb/tb_layer_seq_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/layer_seq_ctrl.sv
// Sequencer for one MVM layer: loads the x vector, walks x-memory/weight ROM per row,
// steers the MAC accumulator and hands each row result downstream with valid/ready.
module layer_seq_ctrl #(
   parameter int M   = 32,
   parameter int N   = 64,
   parameter int AXW = $clog2(N),
   parameter int AWW = $clog2(M*N)
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           s_valid_x,
   output logic           s_ready_x,
   output logic           m_valid_y,
   input  logic           m_ready_y,
   output logic           wr_en_x,
   output logic [AXW-1:0] addr_x,
   output logic [AWW-1:0] addr_w,
   output logic           clear_acc,
   output logic           en_acc
);

   localparam int RW = (M > 1) ? $clog2(M) : 1;
   localparam logic [AXW-1:0] COL_LAST = AXW'(N-1);
   localparam logic [RW-1:0]  ROW_LAST = RW'(M-1);

   typedef enum logic [1:0] {LOAD, COMPUTE, DRAIN, OUT} state_t;

   state_t         state;
   logic [AXW-1:0] col;
   logic [RW-1:0]  row;
   logic [AXW-1:0] addr_x_r;
   logic [AWW-1:0] addr_w_r;
   logic           en_r, clr_r, mv_r;

   // addr_w is kept as a running counter: row*N+col advances by one per column,
   // and the step from the last column of a row to the next row is also +1.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state    <= LOAD;
         col      <= '0;
         row      <= '0;
         addr_x_r <= '0;
         addr_w_r <= '0;
         en_r     <= 1'b0;
         clr_r    <= 1'b0;
         mv_r     <= 1'b0;
      end else begin
         en_r  <= (state == COMPUTE);
         clr_r <= (state == COMPUTE) && (col == '0);
         case (state)
            LOAD: begin
               if (s_valid_x) begin
                  if (col == COL_LAST) begin
                     col      <= '0;
                     row      <= '0;
                     addr_x_r <= '0;
                     addr_w_r <= '0;
                     state    <= COMPUTE;
                  end else begin
                     col      <= col + AXW'(1);
                     addr_x_r <= col + AXW'(1);
                  end
               end
            end
            COMPUTE: begin
               if (col == COL_LAST) begin
                  col   <= '0;
                  state <= DRAIN;
               end else begin
                  col      <= col + AXW'(1);
                  addr_x_r <= col + AXW'(1);
                  addr_w_r <= addr_w_r + AWW'(1);
               end
            end
            DRAIN: begin
               mv_r  <= 1'b1;
               state <= OUT;
            end
            OUT: begin
               if (m_ready_y) begin
                  mv_r     <= 1'b0;
                  addr_x_r <= '0;
                  if (row == ROW_LAST) begin
                     row      <= '0;
                     addr_w_r <= '0;
                     state    <= LOAD;
                  end else begin
                     row      <= row + RW'(1);
                     addr_w_r <= addr_w_r + AWW'(1);
                     state    <= COMPUTE;
                  end
               end
            end
            default: state <= LOAD;
         endcase
      end
   end

   // Everything is forced low while reset is held, even before the first reset edge.
   assign s_ready_x = reset & (state == LOAD);
   assign wr_en_x   = s_valid_x & s_ready_x;
   assign m_valid_y = reset & mv_r;
   assign en_acc    = reset & en_r;
   assign clear_acc = reset & clr_r;
   assign addr_x    = reset ? addr_x_r : '0;
   assign addr_w    = reset ? addr_w_r : '0;

endmodule

// File: tb/tb_layer_seq_ctrl.sv
// Directed bench for layer_seq_ctrl at M=2, N=3: cycle table for the basic flow plus
// hand sequences for input gaps, output backpressure and reset mid-compute.
module tb_layer_seq_ctrl;

   localparam int M = 2;
   localparam int N = 3;

   logic       clk = 1'b0;
   logic       reset;
   logic       s_valid_x, s_ready_x, m_valid_y, m_ready_y, wr_en_x;
   logic [1:0] addr_x;
   logic [2:0] addr_w;
   logic       clear_acc, en_acc;

   int n_chk  = 0;
   int n_fail = 0;

   layer_seq_ctrl #(.M(M), .N(N)) dut (
      .clk(clk), .reset(reset),
      .s_valid_x(s_valid_x), .s_ready_x(s_ready_x),
      .m_valid_y(m_valid_y), .m_ready_y(m_ready_y),
      .wr_en_x(wr_en_x), .addr_x(addr_x), .addr_w(addr_w),
      .clear_acc(clear_acc), .en_acc(en_acc)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       rst, sv, mr;
      logic       sr, wr, mv, en, clr;
      logic [1:0] ax;
      logic [2:0] aw;
   } vec_t;

   vec_t tbl [15];

   function automatic vec_t mk(input logic rst, sv, mr, sr, wr, mv, en, clr,
                               input logic [1:0] ax, input logic [2:0] aw);
      vec_t v;
      v = '{rst, sv, mr, sr, wr, mv, en, clr, ax, aw};
      return v;
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic chk_all_zero(input string nm);
      chk({nm, ".s_ready"}, s_ready_x, 0);
      chk({nm, ".wr_en"},   wr_en_x,   0);
      chk({nm, ".m_valid"}, m_valid_y, 0);
      chk({nm, ".en_acc"},  en_acc,    0);
      chk({nm, ".clear"},   clear_acc, 0);
      chk({nm, ".addr_x"},  addr_x,    0);
      chk({nm, ".addr_w"},  addr_w,    0);
   endtask

   // Inputs change on the falling edge; outputs are sampled 1ns later.
   task automatic step();
      @(negedge clk);
   endtask

   initial begin
      //           rst sv mr  sr wr mv en clr ax aw
      tbl[0]  = mk(0, 1, 1,  0, 0, 0, 0, 0,  0, 0);
      tbl[1]  = mk(1, 1, 1,  1, 1, 0, 0, 0,  0, 0);
      tbl[2]  = mk(1, 1, 1,  1, 1, 0, 0, 0,  1, 0);
      tbl[3]  = mk(1, 1, 1,  1, 1, 0, 0, 0,  2, 0);
      tbl[4]  = mk(1, 1, 1,  0, 0, 0, 0, 0,  0, 0);
      tbl[5]  = mk(1, 1, 1,  0, 0, 0, 1, 1,  1, 1);
      tbl[6]  = mk(1, 1, 1,  0, 0, 0, 1, 0,  2, 2);
      tbl[7]  = mk(1, 1, 1,  0, 0, 0, 1, 0,  2, 2);
      tbl[8]  = mk(1, 1, 1,  0, 0, 1, 0, 0,  2, 2);
      tbl[9]  = mk(1, 1, 1,  0, 0, 0, 0, 0,  0, 3);
      tbl[10] = mk(1, 1, 1,  0, 0, 0, 1, 1,  1, 4);
      tbl[11] = mk(1, 1, 1,  0, 0, 0, 1, 0,  2, 5);
      tbl[12] = mk(1, 1, 1,  0, 0, 0, 1, 0,  2, 5);
      tbl[13] = mk(1, 1, 1,  0, 0, 1, 0, 0,  2, 5);
      tbl[14] = mk(1, 1, 1,  1, 1, 0, 0, 0,  0, 0);

      reset = 1'b0; s_valid_x = 1'b0; m_ready_y = 1'b0;
      repeat (2) @(posedge clk);

      // Basic flow, one table row per clock cycle.
      for (int i = 0; i < 15; i++) begin
         step();
         reset = tbl[i].rst; s_valid_x = tbl[i].sv; m_ready_y = tbl[i].mr;
         #1;
         chk($sformatf("vec%0d.s_ready", i), s_ready_x, tbl[i].sr);
         chk($sformatf("vec%0d.wr_en", i),   wr_en_x,   tbl[i].wr);
         chk($sformatf("vec%0d.m_valid", i), m_valid_y, tbl[i].mv);
         chk($sformatf("vec%0d.en_acc", i),  en_acc,    tbl[i].en);
         chk($sformatf("vec%0d.clear", i),   clear_acc, tbl[i].clr);
         chk($sformatf("vec%0d.addr_x", i),  addr_x,    tbl[i].ax);
         chk($sformatf("vec%0d.addr_w", i),  addr_w,    tbl[i].aw);
      end

      // Reset discards the partial vector; outputs are low while reset is held.
      step(); reset = 1'b0; s_valid_x = 1'b1; #1;
      chk_all_zero("rst_hold");

      // Input gaps: only handshakes advance col.
      begin
         logic gap_pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
         int beats = 0;
         int writes = 0;
         for (int c = 0; c < 6; c++) begin
            step(); reset = 1'b1; s_valid_x = gap_pat[c]; m_ready_y = 1'b0; #1;
            chk($sformatf("gap%0d.s_ready", c), s_ready_x, 1);
            chk($sformatf("gap%0d.wr_en", c),   wr_en_x,   gap_pat[c]);
            chk($sformatf("gap%0d.addr_x", c),  addr_x,    beats);
            if (wr_en_x) writes++;
            if (gap_pat[c]) beats++;
         end
         chk("gap.writes", writes, N);
      end

      // First COMPUTE cycle after the third beat; valid held high must not write.
      step(); s_valid_x = 1'b1; #1;
      chk("gap.compute.s_ready", s_ready_x, 0);
      chk("gap.compute.wr_en",   wr_en_x,   0);
      chk("gap.compute.addr_x",  addr_x,    0);
      chk("gap.compute.addr_w",  addr_w,    0);

      // Backpressure: m_valid_y appears N+1 cycles after COMPUTE entry, then holds.
      begin
         int lat = 0;
         bit seen = 0;
         for (int c = 0; c < 20 && !seen; c++) begin
            step(); s_valid_x = 1'b0; m_ready_y = 1'b0; #1;
            lat++;
            if (m_valid_y) seen = 1;
         end
         chk("bp.latency", lat, N + 1);
         chk("bp.seen", seen, 1);
      end
      for (int c = 0; c < 10; c++) begin
         step(); m_ready_y = 1'b0; #1;
         chk($sformatf("bp%0d.m_valid", c), m_valid_y, 1);
         chk($sformatf("bp%0d.en_acc", c),  en_acc,    0);
         chk($sformatf("bp%0d.addr_x", c),  addr_x,    2);
         chk($sformatf("bp%0d.addr_w", c),  addr_w,    2);
      end
      step(); m_ready_y = 1'b1; #1;
      chk("bp.hs.m_valid", m_valid_y, 1);
      step(); m_ready_y = 1'b1; #1;
      chk("bp.row1.m_valid", m_valid_y, 0);
      chk("bp.row1.addr_x",  addr_x,    0);
      chk("bp.row1.addr_w",  addr_w,    3);
      chk("bp.row1.s_ready", s_ready_x, 0);

      // Reset during COMPUTE of row 1 (second column).
      step(); reset = 1'b0; #1;
      chk_all_zero("rst_mid");
      step(); reset = 1'b1; s_valid_x = 1'b1; m_ready_y = 1'b1; #1;
      chk("rst_mid.after.s_ready", s_ready_x, 1);
      chk("rst_mid.after.addr_x",  addr_x,    0);
      chk("rst_mid.after.en_acc",  en_acc,    0);
      chk("rst_mid.after.clear",   clear_acc, 0);
      chk("rst_mid.after.m_valid", m_valid_y, 0);

      // Full vector after reset: accumulator control counts, restart at row 0.
      begin
         int writes = 0, ens = 0, clrs = 0, outs = 0, stray = 0, k = 0;
         int clr_aw [2] = '{7, 7};
         for (int c = 0; c < N + M * (N + 2); c++) begin
            if (c > 0) begin
               step(); s_valid_x = 1'b1; m_ready_y = 1'b1; #1;
            end
            if (wr_en_x) writes++;
            if (en_acc) ens++;
            if (clear_acc) begin
               clrs++;
               if (!en_acc) stray++;
               if (k < 2) clr_aw[k] = addr_w;
               k++;
            end
            if (m_valid_y && m_ready_y) outs++;
         end
         chk("full.writes",   writes, N);
         chk("full.en_count", ens,    M * N);
         chk("full.clr_count", clrs,  M);
         chk("full.clr_no_en", stray, 0);
         chk("full.outputs",  outs,   M);
         chk("full.clr_aw0",  clr_aw[0], 1);
         chk("full.clr_aw1",  clr_aw[1], 4);
      end
      step(); #1;
      chk("full.back_to_load", s_ready_x, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
